// File: rtl/ntt_pkg.sv
// Shared types and helpers for the NTT twiddle loader.
package ntt_pkg;

    localparam int unsigned NTT_MODULUS = 7681;

    typedef enum logic [2:0] {
        StIdle,
        StGen,
        StSq,
        StWait,
        StDone,
        StErr
    } loader_state_e;

    // Number of twiddle entries held by stage s.
    function automatic int unsigned depth_of(input int unsigned radix, input int unsigned s);
        return radix >> (s + 1);
    endfunction

endpackage

// File: rtl/mod_mul.sv
// Combinational modular multiply: r = a*b mod MODULUS over a full 2W-bit product.
module mod_mul
    import ntt_pkg::*;
#(
    parameter int unsigned W       = 32,
    parameter int unsigned MODULUS = NTT_MODULUS
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] r
);

    assign r = W'(((2 * W)'(a) * (2 * W)'(b)) % (2 * W)'(MODULUS));

endmodule

// File: rtl/ntt_twiddle_loader.sv
// Twiddle-RAM initiator: streams OMEGA^(k*2^s) mod MODULUS into each stage's RAM,
// then waits for every stage's full_ram flag before raising loaded.
module ntt_twiddle_loader
    import ntt_pkg::*;
#(
    parameter int unsigned W       = 32,
    parameter int unsigned RADIX   = 16,
    parameter int unsigned MODULUS = NTT_MODULUS,
    parameter int unsigned OMEGA   = 2,
    parameter int unsigned TIMEOUT = 16,
    localparam int unsigned NS     = $clog2(RADIX),
    localparam int unsigned AW     = $clog2(RADIX / 2)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [NS-1:0]           full_ram,
    output logic [NS-1:0]           write_en_array,
    output logic [NS-1:0][W-1:0]    write_data_array,
    output logic [NS-1:0][AW-1:0]   write_addr_array,
    output logic                    busy,
    output logic                    loaded,
    output logic                    error
);

    localparam int unsigned SW = (NS > 1) ? $clog2(NS) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0]  OMEGA_RED = W'(OMEGA % MODULUS);
    localparam logic [SW-1:0] LAST_S    = SW'(NS - 1);
    localparam logic [TW-1:0] LAST_T    = TW'(TIMEOUT - 1);

    loader_state_e state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [AW-1:0] k_q, k_d, last_k;
    logic [W-1:0]  acc_q, acc_d, stepw_q, stepw_d;
    logic [W-1:0]  acc_prod, stepw_sq;
    logic [TW-1:0] tcnt_q, tcnt_d;

    logic [NS-1:0]         en_d;
    logic [NS-1:0][W-1:0]  data_d;
    logic [NS-1:0][AW-1:0] addr_d;
    logic                  busy_d;

    mod_mul #(
        .W       (W),
        .MODULUS (MODULUS)
    ) u_mul_acc (
        .a (acc_q),
        .b (stepw_q),
        .r (acc_prod)
    );

    mod_mul #(
        .W       (W),
        .MODULUS (MODULUS)
    ) u_mul_sq (
        .a (stepw_q),
        .b (stepw_q),
        .r (stepw_sq)
    );

    assign last_k = AW'(depth_of(RADIX, 32'(s_q)) - 1);

    // s/k/acc hold the write currently shown on the lanes while in StGen.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        acc_d   = acc_q;
        stepw_d = stepw_q;
        tcnt_d  = tcnt_q;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (load) begin
                    state_d = StGen;
                    s_d     = '0;
                    k_d     = '0;
                    acc_d   = W'(1);
                    stepw_d = OMEGA_RED;
                end
            end
            StGen: begin
                acc_d = acc_prod;
                k_d   = k_q + AW'(1);
                if (k_q == last_k) begin
                    if (s_q == LAST_S) begin
                        state_d = StWait;
                        tcnt_d  = '0;
                    end else begin
                        state_d = StSq;
                    end
                end
            end
            StSq: begin
                stepw_d = stepw_sq;
                acc_d   = W'(1);
                k_d     = '0;
                s_d     = s_q + SW'(1);
                state_d = StGen;
            end
            StWait: begin
                tcnt_d = tcnt_q + TW'(1);
                if (&full_ram) begin
                    state_d = StDone;
                end else if (tcnt_q == LAST_T) begin
                    state_d = StErr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        en_d   = '0;
        data_d = '0;
        addr_d = '0;
        if (state_d == StGen) begin
            en_d[s_d]   = 1'b1;
            data_d[s_d] = acc_d;
            addr_d[s_d] = k_d;
        end
        busy_d = state_d inside {StGen, StSq, StWait};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            s_q              <= '0;
            k_q              <= '0;
            acc_q            <= '0;
            stepw_q          <= '0;
            tcnt_q           <= '0;
            write_en_array   <= '0;
            write_data_array <= '0;
            write_addr_array <= '0;
            busy             <= 1'b0;
            loaded           <= 1'b0;
            error            <= 1'b0;
        end else begin
            state_q          <= state_d;
            s_q              <= s_d;
            k_q              <= k_d;
            acc_q            <= acc_d;
            stepw_q          <= stepw_d;
            tcnt_q           <= tcnt_d;
            write_en_array   <= en_d;
            write_data_array <= data_d;
            write_addr_array <= addr_d;
            busy             <= busy_d;
            loaded           <= (state_d == StDone);
            error            <= (state_d == StErr);
        end
    end

endmodule

// File: tb/tb_ntt_twiddle_loader.sv
// Self-checking bench for ntt_twiddle_loader: OMEGA=2 and OMEGA=100 instances run side by side.
module tb_ntt_twiddle_loader;

    localparam int RADIX  = 16;
    localparam int NS     = 4;
    localparam int AW     = 3;
    localparam int W      = 32;
    localparam longint M  = 7681;
    localparam int GENCYC = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, load;
    logic [NS-1:0] full_ram, full_ram100;

    logic [NS-1:0]         en2, en100;
    logic [NS-1:0][W-1:0]  data2, data100;
    logic [NS-1:0][AW-1:0] addr2, addr100;
    logic busy2, loaded2, error2, busy100, loaded100, error100;

    int   nerr = 0;
    int   nchk = 0;
    int   cyc = 0;
    int   rst_cyc = 1000000;
    logic track = 1'b0;

    ntt_twiddle_loader #(
        .W(W), .RADIX(RADIX), .MODULUS(7681), .OMEGA(2), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .full_ram(full_ram),
        .write_en_array(en2), .write_data_array(data2), .write_addr_array(addr2),
        .busy(busy2), .loaded(loaded2), .error(error2)
    );

    ntt_twiddle_loader #(
        .W(W), .RADIX(RADIX), .MODULUS(7681), .OMEGA(100), .TIMEOUT(16)
    ) dut100 (
        .clk(clk), .rst(rst), .load(load), .full_ram(full_ram100),
        .write_en_array(en100), .write_data_array(data100), .write_addr_array(addr100),
        .busy(busy100), .loaded(loaded100), .error(error100)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s (cycle %0d): got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    function automatic longint modpow(input longint b, input int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % M;
        return r;
    endfunction

    // Write schedule: stage s entries in order, one bubble between stages, first write at cycle 1.
    function automatic void exp_lanes(input int c, input longint omega,
                                      output logic [NS-1:0] en,
                                      output logic [NS-1:0][W-1:0] data,
                                      output logic [NS-1:0][AW-1:0] addr);
        int cc = 1;
        en = '0;
        data = '0;
        addr = '0;
        for (int s = 0; s < NS; s++) begin
            for (int k = 0; k < (RADIX >> (s + 1)); k++) begin
                if (cc == c) begin
                    en[s]   = 1'b1;
                    data[s] = W'(modpow(omega, k << s));
                    addr[s] = AW'(k);
                end
                cc++;
            end
            if (s < NS - 1) cc++;
        end
    endfunction

    // Advance one cycle, compare lanes against the model, return at the following negedge.
    task automatic tick();
        logic [NS-1:0]         e2, e100;
        logic [NS-1:0][W-1:0]  d2, d100;
        logic [NS-1:0][AW-1:0] a2, a100;
        @(posedge clk);
        cyc++;
        #1;
        if (track) begin
            if (cyc > rst_cyc) begin
                e2 = '0; d2 = '0; a2 = '0;
                e100 = '0; d100 = '0; a100 = '0;
            end else begin
                exp_lanes(cyc, 2, e2, d2, a2);
                exp_lanes(cyc, 100, e100, d100, a100);
            end
            chk("en2", 64'(en2), 64'(e2));
            chk("en100", 64'(en100), 64'(e100));
            for (int i = 0; i < NS; i++) begin
                chk($sformatf("data2[%0d]", i), 64'(data2[i]), 64'(d2[i]));
                chk($sformatf("addr2[%0d]", i), 64'(addr2[i]), 64'(a2[i]));
                chk($sformatf("data100[%0d]", i), 64'(data100[i]), 64'(d100[i]));
                chk($sformatf("addr100[%0d]", i), 64'(addr100[i]), 64'(a100[i]));
                chk($sformatf("data100[%0d]<M", i), 64'(longint'(data100[i]) < M), 64'(1));
            end
            if (cyc > rst_cyc) begin
                chk("busy2 after rst", 64'(busy2), 64'(0));
                chk("busy100 after rst", 64'(busy100), 64'(0));
            end else if (cyc <= GENCYC) begin
                chk("busy2 gen", 64'(busy2), 64'(1));
                chk("busy100 gen", 64'(busy100), 64'(1));
            end
        end
        @(negedge clk);
    endtask

    task automatic start_load();
        rst_cyc = 1000000;
        cyc = 0;
        track = 1'b1;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic run_to(input int n);
        int guard = 0;
        while (cyc < n && guard < 200) begin
            tick();
            guard++;
        end
        chk("run_to reached", 64'(cyc), 64'(n));
    endtask

    initial begin
        rst = 1'b1;
        load = 1'b0;
        full_ram = 4'b1111;
        full_ram100 = 4'b1111;

        // Reset values
        repeat (2) tick();
        chk("rst en", 64'(en2), 64'(0));
        chk("rst data", 64'(data2), 64'(0));
        chk("rst addr", 64'(addr2), 64'(0));
        chk("rst busy", 64'(busy2), 64'(0));
        chk("rst loaded", 64'(loaded2), 64'(0));
        chk("rst error", 64'(error2), 64'(0));
        rst = 1'b0;
        repeat (3) tick();
        chk("idle loaded ignores full_ram", 64'(loaded2), 64'(0));
        chk("idle busy", 64'(busy2), 64'(0));

        // Full load then completion
        full_ram = 4'b0000;
        start_load();
        while (cyc < 21) begin
            tick();
            if (cyc == 2) chk("omega100 k1", 64'(data100[0]), 64'(100));
            if (cyc == 3) chk("omega100 k2", 64'(data100[0]), 64'(2319));
            if (cyc == 4) chk("omega100 k3", 64'(data100[0]), 64'(1470));
            if (cyc == 8) chk("lane0 k7", 64'(data2[0]), 64'(128));
            if (cyc == 9) chk("bubble en", 64'(en2), 64'(0));
            if (cyc == 13) chk("lane1 k3", 64'(data2[1]), 64'(64));
            if (cyc == 18) chk("last en", 64'(en2), 64'(4'b1000));
            if (cyc == 19) chk("wait busy", 64'(busy2), 64'(1));
        end
        chk("c21 loaded", 64'(loaded2), 64'(0));
        chk("c21 busy", 64'(busy2), 64'(1));
        full_ram = 4'b1111;
        tick();
        chk("c22 loaded", 64'(loaded2), 64'(1));
        chk("c22 busy", 64'(busy2), 64'(0));
        chk("c22 error", 64'(error2), 64'(0));

        // Stray load mid-run, then rst in cycle 11
        full_ram = 4'b0000;
        start_load();
        while (cyc < 11) begin
            tick();
            load = (cyc == 5);
        end
        load = 1'b0;
        rst_cyc = 11;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("post-rst loaded", 64'(loaded2), 64'(0));
        repeat (4) tick();

        // Timeout with one stage never full, then restart from ERR
        full_ram = 4'b0111;
        start_load();
        run_to(34);
        chk("c34 error", 64'(error2), 64'(0));
        chk("c34 busy", 64'(busy2), 64'(1));
        tick();
        chk("c35 error", 64'(error2), 64'(1));
        chk("c35 busy", 64'(busy2), 64'(0));
        chk("c35 loaded", 64'(loaded2), 64'(0));
        run_to(40);
        chk("c40 error sticky", 64'(error2), 64'(1));
        start_load();
        chk("restart error clr", 64'(error2), 64'(0));
        chk("restart addr0", 64'(addr2[0]), 64'(0));
        chk("restart data1", 64'(data2[0]), 64'(1));
        run_to(20);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
